tlul_dnsizer_64to32: RTL and testbench

TLUL_DNSIZER_64TO32 -- requirements
Module: tlul_dnsizer_64to32

---
 rtl/tlul_dnsz_pkg.sv | 33 +++
 rtl/tlul_dnsizer_64to32.sv | 153 +++++++++++++++
 tb/tb_tlul_dnsizer_64to32.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tlul_dnsz_pkg.sv
// Shared types and constants for the 64-to-32 TL-UL downsizer.
// Holds the FSM state enum, TL-UL opcodes and the request legality check.
package tlul_dnsz_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LO_REQ,
        LO_RSP,
        HI_REQ,
        HI_RSP,
        RESP
    } state_e;

    localparam logic [2:0] OP_GET         = 3'd4;
    localparam logic [2:0] OP_PUT_FULL    = 3'd0;
    localparam logic [2:0] OP_PUT_PARTIAL = 3'd1;
    localparam logic [2:0] OP_ACK         = 3'd0;
    localparam logic [2:0] OP_ACK_DATA    = 3'd1;

    // A 64-bit beat must be naturally aligned; narrower ones pass through.
    function automatic logic req_legal(
        input logic [2:0] opcode,
        input logic [2:0] size,
        input logic [2:0] addr_lo
    );
        logic op_ok;
        op_ok = (opcode == OP_GET) || (opcode == OP_PUT_FULL) ||
                (opcode == OP_PUT_PARTIAL);
        return op_ok && (size <= 3'd3) &&
               !((size == 3'd3) && (addr_lo != 3'd0));
    endfunction

endpackage

// File: rtl/tlul_dnsizer_64to32.sv
// Splits 64-bit TL-UL requests into one or two 32-bit device beats.
// Ports: clk_i/rst_ni, host A/D channel (h_*), device A/D channel (dev_*).
module tlul_dnsizer_64to32
    import tlul_dnsz_pkg::*;
#(
    parameter int SourceW = 8
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               h_a_valid,
    input  logic [2:0]         h_a_opcode,
    input  logic [2:0]         h_a_param,
    input  logic [2:0]         h_a_size,
    input  logic [SourceW-1:0] h_a_source,
    input  logic [31:0]        h_a_address,
    input  logic [7:0]         h_a_mask,
    input  logic [63:0]        h_a_data,
    output logic               h_a_ready,
    output logic               h_d_valid,
    output logic [2:0]         h_d_opcode,
    output logic [2:0]         h_d_param,
    output logic [2:0]         h_d_size,
    output logic [SourceW-1:0] h_d_source,
    output logic               h_d_sink,
    output logic [63:0]        h_d_data,
    output logic               h_d_denied,
    input  logic               h_d_ready,
    output logic               dev_a_valid,
    output logic [2:0]         dev_a_opcode,
    output logic [2:0]         dev_a_param,
    output logic [1:0]         dev_a_size,
    output logic [SourceW-1:0] dev_a_source,
    output logic [31:0]        dev_a_address,
    output logic [3:0]         dev_a_mask,
    output logic [31:0]        dev_a_data,
    input  logic               dev_a_ready,
    input  logic               dev_d_valid,
    input  logic [2:0]         dev_d_opcode,
    input  logic [2:0]         dev_d_param,
    input  logic [1:0]         dev_d_size,
    input  logic [SourceW-1:0] dev_d_source,
    input  logic               dev_d_sink,
    input  logic [31:0]        dev_d_data,
    input  logic               dev_d_error,
    output logic               dev_d_ready
);

    state_e state_q, state_d;

    logic [2:0]         op_q;
    logic [2:0]         size_q;
    logic [SourceW-1:0] src_q;
    logic [31:0]        addr_q;
    logic [7:0]         mask_q;
    logic [63:0]        data_q;
    logic [63:0]        rdata_q;
    logic               denied_q;
    logic               illegal_q;

    logic accept;
    logic legal;
    logic wide;
    logic hi;
    logic upper;
    logic unused_sigs;

    assign accept = h_a_valid && h_a_ready;
    assign legal  = req_legal(h_a_opcode, h_a_size, h_a_address[2:0]);
    assign wide   = (size_q == 3'd3);
    assign hi     = (state_q == HI_REQ);
    // Narrow beats pick the lane from the address; wide ones by beat.
    assign upper  = wide ? hi : addr_q[2];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:   if (h_a_valid) state_d = legal ? LO_REQ : RESP;
            LO_REQ: if (dev_a_ready) state_d = LO_RSP;
            LO_RSP: if (dev_d_valid) state_d = wide ? HI_REQ : RESP;
            HI_REQ: if (dev_a_ready) state_d = HI_RSP;
            HI_RSP: if (dev_d_valid) state_d = RESP;
            RESP:   if (h_d_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            op_q      <= '0;
            size_q    <= '0;
            src_q     <= '0;
            addr_q    <= '0;
            mask_q    <= '0;
            data_q    <= '0;
            rdata_q   <= '0;
            denied_q  <= 1'b0;
            illegal_q <= 1'b0;
        end else if (accept) begin
            op_q      <= h_a_opcode;
            size_q    <= h_a_size;
            src_q     <= h_a_source;
            addr_q    <= h_a_address;
            mask_q    <= h_a_mask;
            data_q    <= h_a_data;
            rdata_q   <= '0;
            denied_q  <= !legal;
            illegal_q <= !legal;
        end else if (dev_d_valid && dev_d_ready) begin
            denied_q <= denied_q | dev_d_error;
            if (state_q == HI_RSP) begin
                rdata_q[63:32] <= dev_d_data;
            end else if (wide) begin
                rdata_q[31:0] <= dev_d_data;
            end else begin
                rdata_q <= {dev_d_data, dev_d_data};
            end
        end
    end

    assign h_a_ready = (state_q == IDLE) && rst_ni;

    assign dev_a_valid   = (state_q == LO_REQ) || (state_q == HI_REQ);
    assign dev_a_opcode  = op_q;
    assign dev_a_param   = 3'd0;
    assign dev_a_size    = wide ? 2'd2 : size_q[1:0];
    assign dev_a_source  = src_q;
    assign dev_a_address = wide ? {addr_q[31:3], hi, 2'b00} : addr_q;
    assign dev_a_mask    = upper ? mask_q[7:4] : mask_q[3:0];
    assign dev_a_data    = upper ? data_q[63:32] : data_q[31:0];

    assign dev_d_ready = (state_q == LO_RSP) || (state_q == HI_RSP);

    assign h_d_valid  = (state_q == RESP);
    assign h_d_opcode = (op_q == OP_GET) ? OP_ACK_DATA : OP_ACK;
    assign h_d_param  = 3'd0;
    assign h_d_size   = size_q;
    assign h_d_source = src_q;
    assign h_d_sink   = 1'b0;
    assign h_d_data   = ((op_q == OP_GET) && !illegal_q) ? rdata_q : 64'd0;
    assign h_d_denied = denied_q;

    assign unused_sigs = ^{h_a_param, dev_d_opcode, dev_d_param,
                           dev_d_size, dev_d_source, dev_d_sink};

endmodule

// File: tb/tb_tlul_dnsizer_64to32.sv
// Randomized self-checking bench for tlul_dnsizer_64to32.
// Host and device are modelled inline; expectations come from TL-UL rules.
module tb_tlul_dnsizer_64to32;

    localparam int SW = 8;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          h_a_valid;
    logic [2:0]    h_a_opcode;
    logic [2:0]    h_a_param;
    logic [2:0]    h_a_size;
    logic [SW-1:0] h_a_source;
    logic [31:0]   h_a_address;
    logic [7:0]    h_a_mask;
    logic [63:0]   h_a_data;
    logic          h_a_ready;
    logic          h_d_valid;
    logic [2:0]    h_d_opcode;
    logic [2:0]    h_d_param;
    logic [2:0]    h_d_size;
    logic [SW-1:0] h_d_source;
    logic          h_d_sink;
    logic [63:0]   h_d_data;
    logic          h_d_denied;
    logic          h_d_ready;
    logic          dev_a_valid;
    logic [2:0]    dev_a_opcode;
    logic [2:0]    dev_a_param;
    logic [1:0]    dev_a_size;
    logic [SW-1:0] dev_a_source;
    logic [31:0]   dev_a_address;
    logic [3:0]    dev_a_mask;
    logic [31:0]   dev_a_data;
    logic          dev_a_ready;
    logic          dev_d_valid;
    logic [2:0]    dev_d_opcode;
    logic [2:0]    dev_d_param;
    logic [1:0]    dev_d_size;
    logic [SW-1:0] dev_d_source;
    logic          dev_d_sink;
    logic [31:0]   dev_d_data;
    logic          dev_d_error;
    logic          dev_d_ready;

    int checks = 0;
    int errors = 0;

    tlul_dnsizer_64to32 #(.SourceW(SW)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .h_a_valid(h_a_valid), .h_a_opcode(h_a_opcode),
        .h_a_param(h_a_param), .h_a_size(h_a_size),
        .h_a_source(h_a_source), .h_a_address(h_a_address),
        .h_a_mask(h_a_mask), .h_a_data(h_a_data),
        .h_a_ready(h_a_ready),
        .h_d_valid(h_d_valid), .h_d_opcode(h_d_opcode),
        .h_d_param(h_d_param), .h_d_size(h_d_size),
        .h_d_source(h_d_source), .h_d_sink(h_d_sink),
        .h_d_data(h_d_data), .h_d_denied(h_d_denied),
        .h_d_ready(h_d_ready),
        .dev_a_valid(dev_a_valid), .dev_a_opcode(dev_a_opcode),
        .dev_a_param(dev_a_param), .dev_a_size(dev_a_size),
        .dev_a_source(dev_a_source), .dev_a_address(dev_a_address),
        .dev_a_mask(dev_a_mask), .dev_a_data(dev_a_data),
        .dev_a_ready(dev_a_ready),
        .dev_d_valid(dev_d_valid), .dev_d_opcode(dev_d_opcode),
        .dev_d_param(dev_d_param), .dev_d_size(dev_d_size),
        .dev_d_source(dev_d_source), .dev_d_sink(dev_d_sink),
        .dev_d_data(dev_d_data), .dev_d_error(dev_d_error),
        .dev_d_ready(dev_d_ready)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One complete host transaction against the inline device model.
    task automatic run_txn(
        input logic [2:0]    op,
        input logic [2:0]    sz,
        input logic [31:0]   ad,
        input logic [7:0]    mk,
        input logic [63:0]   dt,
        input logic [31:0]   bd0,
        input logic [31:0]   bd1,
        input logic [1:0]    errs,
        input int            a_wait,
        input int            d_wait
    );
        logic          legal;
        int            nb;
        int            n;
        logic [SW-1:0] src;
        logic [31:0]   e_addr [2];
        logic [31:0]   e_data [2];
        logic [3:0]    e_mask [2];
        logic [31:0]   beat [2];
        logic [63:0]   e_rd;
        logic          e_den;
        logic [2:0]    e_op;
        logic [1:0]    e_sz;

        src  = SW'($urandom);
        beat[0] = bd0;
        beat[1] = bd1;
        legal = (op == 3'd4 || op == 3'd0 || op == 3'd1) && sz <= 3 &&
                !(sz == 3 && ad[2:0] != 0);
        nb = (sz == 3) ? 2 : 1;
        if (sz == 3) begin
            e_addr[0] = ad & ~32'd7;
            e_addr[1] = (ad & ~32'd7) + 32'd4;
            e_data[0] = dt[31:0];
            e_data[1] = dt[63:32];
            e_mask[0] = mk[3:0];
            e_mask[1] = mk[7:4];
            e_sz = 2'd2;
        end else begin
            e_addr[0] = ad;
            e_data[0] = ad[2] ? dt[63:32] : dt[31:0];
            e_mask[0] = ad[2] ? mk[7:4] : mk[3:0];
            e_addr[1] = 0;
            e_data[1] = 0;
            e_mask[1] = 0;
            e_sz = sz[1:0];
        end
        e_op = (op == 3'd4) ? 3'd1 : 3'd0;
        e_den = !legal || errs[0] || (nb == 2 && errs[1]);
        if (!legal || op != 3'd4) e_rd = 0;
        else if (nb == 2) e_rd = {beat[1], beat[0]};
        else e_rd = {beat[0], beat[0]};

        @(negedge clk_i);
        h_a_valid = 1; h_a_opcode = op; h_a_size = sz;
        h_a_source = src; h_a_address = ad; h_a_mask = mk;
        h_a_data = dt; h_a_param = 3'($urandom);
        check("h_a_ready_idle", 64'(h_a_ready), 64'd1);
        @(negedge clk_i);
        h_a_valid = 0;
        check("h_a_ready_busy", 64'(h_a_ready), 64'd0);

        if (legal) begin
            for (int b = 0; b < nb; b++) begin
                n = 0;
                while (!dev_a_valid && n < 20) begin
                    @(negedge clk_i);
                    n++;
                end
                check("dev_a_latency", 64'(n), 64'd0);
                for (int w = 0; w <= a_wait; w++) begin
                    // Stray D traffic outside a response slot must be ignored.
                    dev_d_valid = (w < a_wait);
                    dev_d_error = 1;
                    dev_d_data = 32'hDEAD0000;
                    check("dev_a_valid", 64'(dev_a_valid), 64'd1);
                    check("dev_a_addr", 64'(dev_a_address), 64'(e_addr[b]));
                    check("dev_a_data", 64'(dev_a_data), 64'(e_data[b]));
                    check("dev_a_mask", 64'(dev_a_mask), 64'(e_mask[b]));
                    check("dev_a_size", 64'(dev_a_size), 64'(e_sz));
                    check("dev_a_op", 64'(dev_a_opcode), 64'(op));
                    check("dev_a_src", 64'(dev_a_source), 64'(src));
                    check("dev_a_param", 64'(dev_a_param), 64'd0);
                    check("dev_d_ready_req", 64'(dev_d_ready), 64'd0);
                    check("h_a_ready_req", 64'(h_a_ready), 64'd0);
                    if (w < a_wait) @(negedge clk_i);
                end
                dev_d_valid = 0;
                dev_d_error = 0;
                dev_a_ready = 1;
                @(negedge clk_i);
                dev_a_ready = 0;
                check("dev_d_ready_rsp", 64'(dev_d_ready), 64'd1);
                check("dev_a_valid_rsp", 64'(dev_a_valid), 64'd0);
                dev_d_valid = 1;
                dev_d_data = beat[b];
                dev_d_error = errs[b];
                @(negedge clk_i);
                dev_d_valid = 0;
                dev_d_error = 0;
            end
        end else begin
            n = 0;
            while (!h_d_valid && n < 20) begin
                check("no_dev_a", 64'(dev_a_valid), 64'd0);
                @(negedge clk_i);
                n++;
            end
        end

        check("h_d_latency", 64'(h_d_valid), 64'd1);
        for (int w = 0; w <= d_wait; w++) begin
            check("h_d_valid", 64'(h_d_valid), 64'd1);
            check("h_d_data", h_d_data, e_rd);
            check("h_d_denied", 64'(h_d_denied), 64'(e_den));
            check("h_d_opcode", 64'(h_d_opcode), 64'(e_op));
            check("h_d_size", 64'(h_d_size), 64'(sz));
            check("h_d_source", 64'(h_d_source), 64'(src));
            check("h_d_param_sink", 64'({h_d_param, h_d_sink}), 64'd0);
            check("h_a_ready_resp", 64'(h_a_ready), 64'd0);
            check("no_dev_a_resp", 64'(dev_a_valid), 64'd0);
            if (w < d_wait) @(negedge clk_i);
        end
        h_d_ready = 1;
        @(negedge clk_i);
        h_d_ready = 0;
        check("h_d_done", 64'(h_d_valid), 64'd0);
        check("h_a_ready_back", 64'(h_a_ready), 64'd1);
    endtask

    initial begin
        logic [2:0]  op;
        logic [2:0]  sz;
        logic [31:0] ad;
        logic [2:0]  ops [6];
        int          n;
        ops[0] = 3'd4; ops[1] = 3'd0; ops[2] = 3'd1;
        ops[3] = 3'd4; ops[4] = 3'd7; ops[5] = 3'd2;

        rst_ni = 0;
        h_a_valid = 0; h_a_opcode = 0; h_a_param = 0; h_a_size = 0;
        h_a_source = 0; h_a_address = 0; h_a_mask = 0; h_a_data = 0;
        h_d_ready = 0; dev_a_ready = 0;
        dev_d_valid = 0; dev_d_opcode = 0; dev_d_param = 0;
        dev_d_size = 0; dev_d_source = 0; dev_d_sink = 0;
        dev_d_data = 0; dev_d_error = 0;
        repeat (3) @(negedge clk_i);
        check("rst_h_a_ready", 64'(h_a_ready), 64'd0);
        check("rst_h_d_valid", 64'(h_d_valid), 64'd0);
        check("rst_dev_a_valid", 64'(dev_a_valid), 64'd0);
        check("rst_dev_d_ready", 64'(dev_d_ready), 64'd0);
        check("rst_h_d_data", h_d_data, 64'd0);
        check("rst_dev_a_addr", 64'(dev_a_address), 64'd0);
        rst_ni = 1;
        @(negedge clk_i);
        check("rel_h_a_ready", 64'(h_a_ready), 64'd1);

        // Directed cases from the block's verification list.
        run_txn(3'd4, 3'd3, 32'h1000, 8'hFF, 64'd0,
                32'h11111111, 32'h22222222, 2'b00, 0, 0);
        run_txn(3'd1, 3'd2, 32'h2004, 8'hF0, 64'hAABBCCDD_00000000,
                32'h0, 32'h0, 2'b00, 0, 0);
        run_txn(3'd4, 3'd3, 32'h3004, 8'hFF, 64'd0,
                32'h0, 32'h0, 2'b00, 0, 0);
        run_txn(3'd7, 3'd2, 32'h3000, 8'hFF, 64'd0,
                32'h0, 32'h0, 2'b00, 0, 0);
        run_txn(3'd4, 3'd3, 32'h4000, 8'hFF, 64'd0,
                32'h12345678, 32'h9ABCDEF0, 2'b10, 0, 0);
        run_txn(3'd4, 3'd3, 32'h5000, 8'hFF, 64'd0,
                32'h0BADF00D, 32'h600DCAFE, 2'b01, 0, 0);
        run_txn(3'd0, 3'd3, 32'h6000, 8'hFF, 64'h01234567_89ABCDEF,
                32'h0, 32'h0, 2'b00, 5, 3);
        run_txn(3'd4, 3'd2, 32'h7000, 8'h0F, 64'd0,
                32'hCAFEBABE, 32'h0, 2'b00, 5, 3);
        run_txn(3'd4, 3'd4, 32'h7000, 8'hFF, 64'd0,
                32'h0, 32'h0, 2'b00, 0, 1);

        // Reset while the device response is outstanding.
        @(negedge clk_i);
        h_a_valid = 1; h_a_opcode = 3'd4; h_a_size = 3'd3;
        h_a_address = 32'h8000; h_a_mask = 8'hFF;
        @(negedge clk_i);
        h_a_valid = 0;
        dev_a_ready = 1;
        @(negedge clk_i);
        dev_a_ready = 0;
        check("mid_dev_d_ready", 64'(dev_d_ready), 64'd1);
        rst_ni = 0;
        #1;
        check("mid_rst_h_d_valid", 64'(h_d_valid), 64'd0);
        check("mid_rst_dev_d_ready", 64'(dev_d_ready), 64'd0);
        @(negedge clk_i);
        rst_ni = 1;
        n = 0;
        repeat (3) begin
            @(negedge clk_i);
            if (h_d_valid || dev_a_valid) n++;
        end
        check("mid_rst_quiet", 64'(n), 64'd0);
        check("mid_rst_idle", 64'(h_a_ready), 64'd1);
        run_txn(3'd4, 3'd3, 32'h9000, 8'hFF, 64'd0,
                32'h55555555, 32'h66666666, 2'b00, 1, 1);

        // Randomized traffic.
        for (int i = 0; i < 60; i++) begin
            op = ops[$urandom_range(0, 5)];
            sz = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(4, 7))
                                             : 3'($urandom_range(0, 3));
            ad = $urandom;
            if ($urandom_range(0, 3) != 0)
                ad = ad & ~((32'd1 << (sz > 3 ? 3 : sz)) - 32'd1);
            run_txn(op, sz, ad, 8'($urandom), {$urandom, $urandom},
                    $urandom, $urandom, 2'($urandom_range(0, 7) == 0 ?
                    $urandom_range(1, 3) : 0),
                    $urandom_range(0, 3), $urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
